mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
//  Multi-cycle controller for the multiply/divide unit in execute (E) stage. Accepts an op from decode-generated
//  Start/MDUOP/Time, holds HI/LO, sequences the latency with a busy counter, and raises a stall to the hazard
//  unit for MD-type instructions in D while an op is in flight. Feeds HI/LO into the E-stage result mux (mfhi/mflo).
// PARAMETERS
//  DATA_W   32  operand / HI / LO width
//  CNT_W    4   busy-counter width; max latency 2**CNT_W-1 cycles
// PORTS
//  clk       in   1       rising-edge clock
//  reset     in   1       synchronous, active-high reset
//  Start     in   1       E-stage mult/multu/div/divu issue strobe
//  MDUOP     in   4       op: 0001 mult,0010 multu,0011 div,0100 divu,0101 mthi,0110 mtlo,1000 shl,1111 mf*,0000 none
//  Time      in   CNT_W   op latency from decode (5 mult, 10 div)
//  A         in   DATA_W  forwarded rs value (E)
//  B         in   DATA_W  forwarded rt value (E)
//  ReadHILO  in   2       10 read HI, 01 read LO, else 0
//  MDTypeD   in   1       D-stage instruction is MD type (incl. mfhi/mflo/mthi/mtlo/shl)
//  Stall     out  1       hold F/D, bubble E (combinational)
//  Busy      out  1       op in flight (registered)
//  HILOOut   out  DATA_W  HI/LO value selected by ReadHILO
// BEHAVIOUR
//  Reset: state IDLE, cnt=0, HI=LO=0, pending regs=0, Busy=0. Stall/HILOOut combinational from reset state.
//  FSM IDLE->BUSY: Start=1 in IDLE. Latch A,B,MDUOP; compute 64-bit pending {PH,PL}; cnt<=max(Time,1).
//  BUSY: cnt decrements each cycle; on cnt==1 -> HI<=PH, LO<=PL, cnt<=0, ->IDLE.
//  Timing: Start at edge t -> Busy=1 during cycles t+1..t+Time; new HI/LO visible from t+Time+1 (Time=5 -> 5 busy cycles).
//  Arithmetic: mult = signed 64b A*B; multu = unsigned; div: PL=A/B, PH=A%B signed (quotient toward zero,
//   remainder sign of A); divu unsigned. Divide by zero: PH=HI, PL=LO (HI/LO unchanged), full latency still spent.
//  mthi/mtlo: single-cycle, write HI<=A / LO<=A on the edge, only in IDLE; no Busy.
//  shl: single-cycle, {HI,LO} <= {HI,LO} << A[5:0] (zero fill), only in IDLE; no Busy.
//  mf*/none: no state change.
//  HILOOut: ReadHILO 10 -> HI, 01 -> LO, else 0; reads committed regs (not pending).
//  Stall = MDTypeD & (Busy | Start). Covers the Start cycle itself, so D cannot issue mfhi behind a fresh mult.
//  Start, mthi, mtlo, shl while Busy: ignored (hazard unit guarantees absence; assertion in bench).
//  Start and MDTypeD same cycle: Stall=1. Last busy cycle (cnt==1): Busy still 1, Stall still asserted.
//  Reset mid-operation: abort, pending discarded, HI=LO=0, IDLE next cycle.
//  Time >= 2**CNT_W is impossible by width; Time=0 with Start treated as 1.
// STRUCTURE
//  Shared package mdu_defs: MDUOP encodings (MDU_MULT..MDU_SHL, MDU_MF), ReadHILO encodings, state enum
//   {IDLE,BUSY}, latency constants MULT_T=5, DIV_T=10 (also used by decoder).
//  One sub-module: mdu_arith (combinational op,A,B,HI,LO -> 64-bit {PH,PL}); sequencer owns FSM, counter, regs.
// TESTING
//  1 mult A=-3,B=7,Time=5, then mflo -> Busy 5 cycles; LO=0xFFFFFFEB, HI=0xFFFFFFFF at t+6; earlier reads old.
//  2 divu A=100,B=7,Time=10 with MDTypeD=1 throughout -> Stall 11 cycles (t..t+10); LO=14, HI=2 after.
//  3 div A=-7,B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; div A=5,B=0 -> HI/LO unchanged, Busy 10 cycles.
//  4 mthi 0x1, mtlo 0x80000000, shl A=1 -> HI=0x3, LO=0x0 next cycle, Busy never 1, Stall only if MDTypeD&Start.
//  5 reset at cnt=3 of mult -> Busy=0, HI=LO=0 next cycle; following mult completes normally.
//  6 Start with Time=0, A=2,B=3 multu -> Busy 1 cycle, LO=6 at t+2; non-MD D instr never stalls.

Source files
------------

// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit: op encodings, HI/LO read
// selects, sequencer states and the latencies the decoder hands to Time.
package mdu_defs;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'b0000,
        MDU_MULT  = 4'b0001,
        MDU_MULTU = 4'b0010,
        MDU_DIV   = 4'b0011,
        MDU_DIVU  = 4'b0100,
        MDU_MTHI  = 4'b0101,
        MDU_MTLO  = 4'b0110,
        MDU_SHL   = 4'b1000,
        MDU_MF    = 4'b1111
    } mdu_op_e;

    localparam logic [1:0] RD_HI = 2'b10;
    localparam logic [1:0] RD_LO = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam int unsigned MULT_T = 32'd5;
    localparam int unsigned DIV_T  = 32'd10;

    // True for the ops that run through the busy counter.
    function automatic logic is_long_op(input logic [3:0] op);
        logic long_s;
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: long_s = 1'b1;
            default:                                long_s = 1'b0;
        endcase
        return long_s;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core: produces the 64-bit {PH,PL} result of a
// multiply or divide. Divide by zero returns the current {HI,LO} so the
// registers come out unchanged after the op retires.
module mdu_arith
    import mdu_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]          op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [DATA_W-1:0]   hi,
    input  logic [DATA_W-1:0]   lo,
    output logic [2*DATA_W-1:0] res
);

    logic signed [2*DATA_W-1:0] a_sx_s;
    logic signed [2*DATA_W-1:0] b_sx_s;
    logic        [2*DATA_W-1:0] a_zx_s;
    logic        [2*DATA_W-1:0] b_zx_s;
    logic                       div_zero_s;
    logic        [DATA_W-1:0]   b_safe_s;
    logic signed [DATA_W-1:0]   sq_s;
    logic signed [DATA_W-1:0]   sr_s;
    logic        [DATA_W-1:0]   uq_s;
    logic        [DATA_W-1:0]   ur_s;

    assign a_sx_s = {{DATA_W{a[DATA_W-1]}}, a};
    assign b_sx_s = {{DATA_W{b[DATA_W-1]}}, b};
    assign a_zx_s = {{DATA_W{1'b0}}, a};
    assign b_zx_s = {{DATA_W{1'b0}}, b};

    // The divider never sees zero; the zero case is handled by the result mux.
    assign div_zero_s = (b == {DATA_W{1'b0}});
    assign b_safe_s   = div_zero_s ? {{(DATA_W-1){1'b0}}, 1'b1} : b;

    // Signed divide truncates toward zero; remainder takes the dividend's sign.
    assign sq_s = $signed(a) / $signed(b_safe_s);
    assign sr_s = $signed(a) % $signed(b_safe_s);
    assign uq_s = a / b_safe_s;
    assign ur_s = a % b_safe_s;

    // Select the pending {PH,PL} for the requested operation.
    always_comb begin
        res = {hi, lo};
        case (op)
            MDU_MULT:  res = a_sx_s * b_sx_s;
            MDU_MULTU: res = a_zx_s * b_zx_s;
            MDU_DIV: begin
                if (div_zero_s) begin
                    res = {hi, lo};
                end else begin
                    res = {sr_s, sq_s};
                end
            end
            MDU_DIVU: begin
                if (div_zero_s) begin
                    res = {hi, lo};
                end else begin
                    res = {ur_s, uq_s};
                end
            end
            default:   res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide sequencer. Owns HI/LO, the pending result of an
// in-flight op and the busy counter, and tells the hazard unit to stall
// MD-type instructions in D while an op is launching or in flight.
module mdu_sequencer
    import mdu_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [3:0]        MDUOP,
    input  logic [CNT_W-1:0]  Time,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [1:0]        ReadHILO,
    input  logic              MDTypeD,
    output logic              Stall,
    output logic              Busy,
    output logic [DATA_W-1:0] HILOOut
);

    localparam int SH_W = $clog2(2 * DATA_W);

    mdu_state_e            state_r;
    mdu_state_e            state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic                  busy_r;
    logic [DATA_W-1:0]     hi_r;
    logic [DATA_W-1:0]     lo_r;
    logic [DATA_W-1:0]     ph_r;
    logic [DATA_W-1:0]     pl_r;
    logic [2*DATA_W-1:0]   arith_res_s;
    logic [2*DATA_W-1:0]   shifted_s;
    logic [CNT_W-1:0]      start_time_s;
    logic                  last_s;
    logic                  launch_s;
    logic                  commit_s;
    logic                  wr_hi_s;
    logic                  wr_lo_s;
    logic                  shift_s;

    mdu_arith #(
        .DATA_W (DATA_W)
    ) u_arith (
        .op  (MDUOP),
        .a   (A),
        .b   (B),
        .hi  (hi_r),
        .lo  (lo_r),
        .res (arith_res_s)
    );

    // A zero latency still costs one busy cycle.
    assign start_time_s = (Time == {CNT_W{1'b0}}) ? CNT_W'(1) : Time;
    assign last_s       = (cnt_r <= CNT_W'(1));
    assign shifted_s    = {hi_r, lo_r} << A[SH_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: launch on a long op in IDLE, retire on the last count.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (Start && is_long_op(MDUOP)) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-state control strobes; single-cycle HI/LO writes only happen in IDLE.
    always_comb begin
        launch_s = 1'b0;
        commit_s = 1'b0;
        wr_hi_s  = 1'b0;
        wr_lo_s  = 1'b0;
        shift_s  = 1'b0;
        case (state_r)
            IDLE: begin
                case (MDUOP)
                    MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: launch_s = Start;
                    MDU_MTHI: wr_hi_s = 1'b1;
                    MDU_MTLO: wr_lo_s = 1'b1;
                    MDU_SHL:  shift_s = 1'b1;
                    MDU_MF, MDU_NONE: launch_s = 1'b0;
                    default:  launch_s = 1'b0;
                endcase
            end
            BUSY: begin
                if (last_s) begin
                    commit_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            default: commit_s = 1'b0;
        endcase
    end

    // Busy counter: loaded at launch, counts down to zero while in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (launch_s) begin
            cnt_r <= start_time_s;
        end else if (state_r == BUSY) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Busy flag registered from the next state so it is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == BUSY);
        end
    end

    // Pending result captured at launch; HI/LO stay readable until retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            ph_r <= {DATA_W{1'b0}};
            pl_r <= {DATA_W{1'b0}};
        end else if (launch_s) begin
            ph_r <= arith_res_s[2*DATA_W-1:DATA_W];
            pl_r <= arith_res_s[DATA_W-1:0];
        end else begin
            ph_r <= ph_r;
            pl_r <= pl_r;
        end
    end

    // Committed HI/LO: retire of a long op or a single-cycle move/shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= {DATA_W{1'b0}};
            lo_r <= {DATA_W{1'b0}};
        end else if (commit_s) begin
            hi_r <= ph_r;
            lo_r <= pl_r;
        end else if (wr_hi_s) begin
            hi_r <= A;
        end else if (wr_lo_s) begin
            lo_r <= A;
        end else if (shift_s) begin
            hi_r <= shifted_s[2*DATA_W-1:DATA_W];
            lo_r <= shifted_s[DATA_W-1:0];
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Result-mux read port for mfhi/mflo; always the committed registers.
    always_comb begin
        HILOOut = {DATA_W{1'b0}};
        case (ReadHILO)
            RD_HI:   HILOOut = hi_r;
            RD_LO:   HILOOut = lo_r;
            default: HILOOut = {DATA_W{1'b0}};
        endcase
    end

    // Stall covers the launch cycle so D cannot read HI/LO behind a fresh op.
    assign Stall = MDTypeD & (busy_r | Start);
    assign Busy  = busy_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: a table of long ops whose results
// go through a scoreboard queue, plus hand sequences for moves/shifts and
// a reset in the middle of an operation.
module tb_mdu_sequencer;
    import mdu_defs::*;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          Start;
    logic [3:0]    MDUOP;
    logic [CW-1:0] Time;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [1:0]    ReadHILO;
    logic          MDTypeD;
    logic          Stall;
    logic          Busy;
    logic [DW-1:0] HILOOut;

    always #5 clk = ~clk;

    mdu_sequencer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .MDUOP    (MDUOP),
        .Time     (Time),
        .A        (A),
        .B        (B),
        .ReadHILO (ReadHILO),
        .MDTypeD  (MDTypeD),
        .Stall    (Stall),
        .Busy     (Busy),
        .HILOOut  (HILOOut)
    );

    typedef struct {
        logic [3:0]    op;
        logic [CW-1:0] t;
        logic [31:0]   a;
        logic [31:0]   b;
        logic          md;
        logic [31:0]   hi;
        logic [31:0]   lo;
        int            busy;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    exp_t        sb_q[$];
    vec_t        vecs[10];
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        ReadHILO = RD_HI;
        #1 hi = HILOOut;
        ReadHILO = RD_LO;
        #1 lo = HILOOut;
    endtask

    // Launch one long op, watch the busy window, then retire it through the scoreboard.
    task automatic run_vec(input vec_t v, input string tag);
        int          n;
        exp_t        e;
        logic [31:0] rh;
        logic [31:0] rl;
        Start    = 1'b1;
        MDUOP    = v.op;
        Time     = v.t;
        A        = v.a;
        B        = v.b;
        MDTypeD  = v.md;
        ReadHILO = RD_LO;
        #1;
        check({tag, " stall_launch"}, 64'(Stall), 64'(v.md));
        check({tag, " lo_before"}, 64'(HILOOut), 64'(cur_lo));
        sb_q.push_back('{hi: v.hi, lo: v.lo});
        tick;
        Start = 1'b0;
        MDUOP = MDU_NONE;
        n = 0;
        while (Busy && n < 40) begin
            #1;
            check($sformatf("%s stall_busy%0d", tag, n), 64'(Stall), 64'(v.md));
            check($sformatf("%s lo_old%0d", tag, n), 64'(HILOOut), 64'(cur_lo));
            n++;
            tick;
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(v.busy));
        check({tag, " stall_after"}, 64'(Stall), 64'(0));
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 64'(1), 64'(0));
        end else begin
            e = sb_q.pop_front();
            read_hilo(rh, rl);
            check({tag, " hi"}, 64'(rh), 64'(e.hi));
            check({tag, " lo"}, 64'(rl), 64'(e.lo));
            cur_hi = e.hi;
            cur_lo = e.lo;
        end
    endtask

    // Protocol monitor: the hazard unit must never issue into a busy unit.
    always @(negedge clk) begin
        if (!reset && Busy && (Start || MDUOP == MDU_MTHI || MDUOP == MDU_MTLO || MDUOP == MDU_SHL)) begin
            tests++;
            fails++;
            $display("FAIL protocol: op %0h issued while busy", MDUOP);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rh;
        logic [31:0] rl;
        vec_t        v;

        vecs[0] = '{MDU_MULT,  CW'(MULT_T), 32'hFFFF_FFFD, 32'd7,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
        vecs[1] = '{MDU_MULTU, CW'(MULT_T), 32'hFFFF_FFFF, 32'd2,         1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2] = '{MDU_DIVU,  CW'(DIV_T),  32'd100,       32'd7,         1'b1, 32'd2,         32'd14,        10};
        vecs[3] = '{MDU_DIV,   CW'(DIV_T),  32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[4] = '{MDU_DIV,   CW'(DIV_T),  32'd5,         32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[5] = '{MDU_MULTU, 4'd0,        32'd2,         32'd3,         1'b0, 32'd0,         32'd6,         1};
        vecs[6] = '{MDU_DIV,   CW'(DIV_T),  32'd7,         32'hFFFF_FFFE, 1'b0, 32'd1,         32'hFFFF_FFFD, 10};
        vecs[7] = '{MDU_MULT,  CW'(MULT_T), 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000, 5};
        vecs[8] = '{MDU_DIVU,  CW'(DIV_T),  32'hFFFF_FFFF, 32'h0000_0010, 1'b1, 32'h0000_000F, 32'h0FFF_FFFF, 10};
        vecs[9] = '{MDU_MULT,  4'd15,       32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 15};

        reset    = 1'b1;
        Start    = 1'b0;
        MDUOP    = MDU_NONE;
        Time     = '0;
        A        = '0;
        B        = '0;
        ReadHILO = 2'b00;
        MDTypeD  = 1'b1;
        tick;
        tick;
        check("reset busy", 64'(Busy), 64'(0));
        check("reset stall", 64'(Stall), 64'(0));
        check("reset hilo_none", 64'(HILOOut), 64'(0));
        read_hilo(rh, rl);
        check("reset hi", 64'(rh), 64'(0));
        check("reset lo", 64'(rl), 64'(0));
        reset  = 1'b0;
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        tick;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            tick;
        end

        // Single-cycle moves and shifts: HI=1, LO=0x80000000, shift by 1 -> {3,0}.
        MDTypeD = 1'b1;
        MDUOP   = MDU_MTHI;
        A       = 32'h0000_0001;
        #1 check("mthi stall", 64'(Stall), 64'(0));
        tick;
        check("mthi busy", 64'(Busy), 64'(0));
        MDUOP = MDU_MTLO;
        A     = 32'h8000_0000;
        tick;
        check("mtlo busy", 64'(Busy), 64'(0));
        MDUOP = MDU_SHL;
        A     = 32'h0000_0001;
        tick;
        check("shl busy", 64'(Busy), 64'(0));
        MDUOP = MDU_NONE;
        read_hilo(rh, rl);
        check("shl1 hi", 64'(rh), 64'h3);
        check("shl1 lo", 64'(rl), 64'h0);
        // Only the low six bits of A count: 0x44 shifts by 4.
        MDUOP = MDU_SHL;
        A     = 32'h0000_0044;
        tick;
        MDUOP = MDU_MF;
        tick;
        read_hilo(rh, rl);
        check("shl4 hi", 64'(rh), 64'h30);
        check("shl4 lo", 64'(rl), 64'h0);
        MDUOP  = MDU_NONE;
        cur_hi = 32'h30;
        cur_lo = 32'h0;
        tick;

        // Reset with the counter at 3 aborts the op and clears HI/LO.
        Start = 1'b1;
        MDUOP = MDU_MULT;
        Time  = CW'(MULT_T);
        A     = 32'd9;
        B     = 32'd9;
        tick;
        Start = 1'b0;
        MDUOP = MDU_NONE;
        tick;
        tick;
        check("abort busy_before", 64'(Busy), 64'(1));
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort busy", 64'(Busy), 64'(0));
        read_hilo(rh, rl);
        check("abort hi", 64'(rh), 64'(0));
        check("abort lo", 64'(rl), 64'(0));
        tick;
        check("abort stays_idle", 64'(Busy), 64'(0));
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        v = '{MDU_MULT, CW'(MULT_T), 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 5};
        run_vec(v, "post_abort");
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
